// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC source encoding and reset default for the PC generator
package pc_pkg;

    typedef enum logic [2:0] {
        PC_TRAP,
        PC_MRET,
        PC_REDIR,
        PC_HOLD,
        PC_SEQ
    } pc_src_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_gen_ras.sv
// ras: circular return-address stack; ptr addresses the top entry, cnt saturates at DEPTH
module ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] link,
    output logic [XLEN-1:0] top,
    output logic            valid
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW:0]     cnt;
    logic            empty;
    logic            full;
    logic            do_pop;

    assign empty  = cnt == '0;
    assign full   = cnt == (PW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    assign valid  = !empty;
    assign top    = empty ? '0 : mem[ptr];

    // Push writes above the top (wrapping over the oldest entry when full); push+pop replaces the top
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr <= '0;
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (push && do_pop) begin
            mem[ptr] <= link;
        end else if (push) begin
            mem[ptr + PW'(1)] <= link;
            ptr <= ptr + PW'(1);
            cnt <= full ? cnt : cnt + (PW+1)'(1);
        end else if (do_pop) begin
            ptr <= ptr - PW'(1);
            cnt <= cnt - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program counter with trap/mret/redirect priority mux, alignment check and return-address stack
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int              RAS_DEPTH    = 4,
    parameter int              C_EXT        = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            compressed_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vector_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic            ras_push_i,
    input  logic            ras_pop_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic [XLEN-1:0] ras_top_o,
    output logic            ras_valid_o,
    output logic            misaligned_o
);

    pc_src_e         src;
    logic [XLEN-1:0] align_mask;
    logic [XLEN-1:0] inc;
    logic [XLEN-1:0] link;
    logic            mis_now;
    logic            ras_en;

    assign align_mask = (C_EXT != 0) ? ~XLEN'(1) : ~XLEN'(3);
    assign inc        = (compressed_i && C_EXT != 0) ? XLEN'(2) : XLEN'(4);
    assign link       = pc_o + inc;
    assign ras_en     = src != PC_HOLD;

    // Select the next-PC source by fixed priority; trap and mret win over stall
    always_comb begin
        src = trap_i     ? PC_TRAP  :
              mret_i     ? PC_MRET  :
              redirect_i ? PC_REDIR :
              stall_i    ? PC_HOLD  : PC_SEQ;
    end

    // A misaligned redirect is rejected: the PC holds and a flag is raised for one cycle
    always_comb begin
        mis_now   = (src == PC_REDIR) && ((redirect_target_i & ~align_mask) != '0);
        pc_next_o = rst                ? RESET_VECTOR                :
                    (src == PC_TRAP)   ? (trap_vector_i & align_mask) :
                    (src == PC_MRET)   ? (epc_i & align_mask)         :
                    (src == PC_REDIR)  ? (mis_now ? pc_o : redirect_target_i) :
                    (src == PC_HOLD)   ? pc_o                         : pc_o + inc;
    end

    // PC and misalignment pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o         <= RESET_VECTOR;
            misaligned_o <= 1'b0;
        end else begin
            pc_o         <= pc_next_o;
            misaligned_o <= mis_now;
        end
    end

    ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push_i && ras_en),
        .pop   (ras_pop_i && ras_en),
        .flush (trap_i),
        .link  (link),
        .top   (ras_top_o),
        .valid (ras_valid_o)
    );

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen (C_EXT=1 main instance, C_EXT=0 side instance)
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst, stall, comp, redir, trap, mret, push, pop;
    logic [31:0] tgt, vec, epc;
    logic [31:0] pc, pc_nx, top, pc0, pc_nx0, top0;
    logic        valid, mis, valid0, mis0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_pc[$], q_top[$];
    logic        q_val[$], q_mis[$];
    string       q_tag[$];

    always #5 clk = ~clk;

    pc_gen #(.C_EXT(1)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .compressed_i(comp),
        .redirect_i(redir), .redirect_target_i(tgt), .trap_i(trap), .trap_vector_i(vec),
        .mret_i(mret), .epc_i(epc), .ras_push_i(push), .ras_pop_i(pop),
        .pc_o(pc), .pc_next_o(pc_nx), .ras_top_o(top), .ras_valid_o(valid), .misaligned_o(mis)
    );

    pc_gen #(.C_EXT(0)) dut0 (
        .clk(clk), .rst(rst), .stall_i(stall), .compressed_i(comp),
        .redirect_i(redir), .redirect_target_i(tgt), .trap_i(trap), .trap_vector_i(vec),
        .mret_i(mret), .epc_i(epc), .ras_push_i(push), .ras_pop_i(pop),
        .pc_o(pc0), .pc_next_o(pc_nx0), .ras_top_o(top0), .ras_valid_o(valid0), .misaligned_o(mis0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {rst, stall, comp, redir, trap, mret, push, pop} = '0;
        tgt = '0; vec = '0; epc = '0;
    endtask

    task automatic cycle(input string tag, input logic [31:0] e_pc, input logic [31:0] e_top,
                         input logic e_val, input logic e_mis);
        q_tag.push_back(tag); q_pc.push_back(e_pc); q_top.push_back(e_top);
        q_val.push_back(e_val); q_mis.push_back(e_mis);
        #1;
        chk({tag, "_pcnext"}, pc_nx, e_pc);
        @(posedge clk);
        #1;
        begin
            string t = q_tag.pop_front();
            chk({t, "_pc"},  pc,  q_pc.pop_front());
            chk({t, "_top"}, top, q_top.pop_front());
            chk({t, "_val"}, 32'(valid), 32'(q_val.pop_front()));
            chk({t, "_mis"}, 32'(mis),   32'(q_mis.pop_front()));
        end
        idle();
    endtask

    initial begin
        idle();
        @(posedge clk); #1;
        rst = 1;                          cycle("reset",   32'h0,   32'h0, 0, 0);
        chk("reset0_pc", pc0, 32'h0);
        cycle("seq1", 32'h4, 0, 0, 0);
        cycle("seq2", 32'h8, 0, 0, 0);
        cycle("seq3", 32'hC, 0, 0, 0);
        redir = 1; tgt = 32'h100;         cycle("redir100", 32'h100, 0, 0, 0);
        comp = 1;                         cycle("comp1",    32'h102, 0, 0, 0);
        comp = 1; stall = 1;              cycle("stall",    32'h102, 0, 0, 0);
        comp = 1;                         cycle("comp2",    32'h104, 0, 0, 0);
        redir = 1; tgt = 32'h10;          cycle("to10",     32'h10,  0, 0, 0);
        push = 1; redir = 1; tgt = 32'h20; cycle("push1",   32'h20, 32'h14, 1, 0);
        push = 1; redir = 1; tgt = 32'h30; cycle("push2",   32'h30, 32'h24, 1, 0);
        push = 1; redir = 1; tgt = 32'h40; cycle("push3",   32'h40, 32'h34, 1, 0);
        push = 1; redir = 1; tgt = 32'h50; cycle("push4",   32'h50, 32'h44, 1, 0);
        push = 1;                         cycle("push5",    32'h54, 32'h54, 1, 0);
        pop = 1;                          cycle("pop1",     32'h58, 32'h44, 1, 0);
        pop = 1;                          cycle("pop2",     32'h5C, 32'h34, 1, 0);
        pop = 1;                          cycle("pop3",     32'h60, 32'h24, 1, 0);
        pop = 1;                          cycle("pop4",     32'h64, 32'h0,  0, 0);
        pop = 1;                          cycle("pop_empty", 32'h68, 32'h0, 0, 0);
        redir = 1; tgt = 32'h20;          cycle("to20",     32'h20,  0, 0, 0);
        push = 1; redir = 1; tgt = 32'h60; cycle("push24",  32'h60, 32'h24, 1, 0);
        push = 1; pop = 1;                cycle("pushpop",  32'h64, 32'h64, 1, 0);
        pop = 1;                          cycle("pop_cnt1", 32'h68, 32'h0,  0, 0);
        push = 1; stall = 1;              cycle("stall_push", 32'h68, 32'h0, 0, 0);
        push = 1;                         cycle("push6c",   32'h6C, 32'h6C, 1, 0);
        rst = 1; push = 1; redir = 1; tgt = 32'h400; cycle("mid_rst", 32'h0, 32'h0, 0, 0);
        chk("mid_rst0_pc", pc0, 32'h0);
        push = 1;                         cycle("push4b",   32'h4,  32'h4, 1, 0);
        stall = 1; redir = 1; tgt = 32'h200; trap = 1; vec = 32'h81;
                                          cycle("trap",     32'h80, 32'h0, 0, 0);
        chk("trap0_pc", pc0, 32'h80);
        mret = 1; stall = 1; epc = 32'h123; cycle("mret",   32'h122, 0, 0, 0);
        chk("mret0_pc", pc0, 32'h120);
        stall = 1;                        cycle("hold",     32'h122, 0, 0, 0);
        redir = 1; tgt = 32'h301;         cycle("mis_redir", 32'h122, 0, 0, 1);
        comp = 1;                         cycle("mis_clear", 32'h124, 0, 0, 0);
        chk("c0_seq_pc", pc0, 32'h124);
        redir = 1; tgt = 32'h302;         cycle("redir302", 32'h302, 0, 0, 0);
        chk("c0_mis_pc", pc0, 32'h124);
        chk("c0_mis_hi", 32'(mis0), 32'h1);
        cycle("after302", 32'h306, 0, 0, 0);
        chk("c0_mis_lo", 32'(mis0), 32'h0);
        chk("c0_after_pc", pc0, 32'h128);
        redir = 1; tgt = 32'hFFFF_FFFC;   cycle("to_top",   32'hFFFF_FFFC, 0, 0, 0);
        cycle("wrap", 32'h0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
